// File: rtl/interrupt_ack_controller.sv
// ---------------------------------------------------------------------------
// interrupt_ack_controller
//
// CPU-side half of an 8259-style interrupt controller. It picks the highest
// priority unmasked request that can pre-empt whatever is already in service,
// raises INT, then walks the two-pulse INTA acknowledge. On the first pulse it
// latches the level, marks it in service and pulses `chosen` so the request
// register can drop that IRR bit. On the second pulse it drives the vector
// {vec_base, level} onto the data bus. In-service levels retire on an EOI
// command or, in automatic-EOI mode, at the end of the second pulse.
//
// Ports
//   CLK          : system clock, rising edge
//   RST_N        : asynchronous active-low reset
//   IRR[7:0]     : pending requests, bit 0 = IR0 (highest priority)
//   IMR[7:0]     : mask, 1 = level masked
//   INTA_N       : CPU acknowledge, active low, synchronous to CLK
//   vec_base     : vector base T, forms data_out[7:3]
//   aeoi         : automatic EOI mode
//   eoi          : one-cycle EOI command strobe
//   eoi_specific : 1 = clear eoi_level, 0 = clear highest in-service level
//   eoi_level    : level for a specific EOI
//   INT          : registered interrupt request to the CPU
//   chosen[7:0]  : one-hot, one-cycle pulse of the acknowledged level
//   ISR[7:0]     : in-service register
//   data_out     : vector byte
//   data_oe      : data bus drive enable
// ---------------------------------------------------------------------------
module interrupt_ack_controller #(
  parameter int VEC_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       IRR,
  input  logic [7:0]       IMR,
  input  logic             INTA_N,
  input  logic [VEC_W-1:0] vec_base,
  input  logic             aeoi,
  input  logic             eoi,
  input  logic             eoi_specific,
  input  logic [2:0]       eoi_level,
  output logic             INT,
  output logic [7:0]       chosen,
  output logic [7:0]       ISR,
  output logic [7:0]       data_out,
  output logic             data_oe
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_e;

  state_e     state_q;
  logic       inta_prev_q;
  logic       int_q;
  logic [7:0] chosen_q;
  logic [7:0] isr_q;
  logic [7:0] isr_d;
  logic [7:0] data_out_q;
  logic       data_oe_q;
  logic [2:0] lvl_q;
  logic       spur_q;

  logic [7:0] req;
  logic [2:0] topReq;
  logic [2:0] topIsr;
  logic       reqValid;
  logic       fall;
  logic       rise;
  logic [7:0] isrSet;
  logic [7:0] isrClr;

  assign req  = IRR & ~IMR;
  assign fall = inta_prev_q & ~INTA_N;
  assign rise = ~inta_prev_q & INTA_N;

  // Lowest set bit wins; scanning downward lets the last hit be the winner.
  always_comb begin
    topReq = 3'd7;
    topIsr = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (req[i])   topReq = 3'(i);
      if (isr_q[i]) topIsr = 3'(i);
    end
  end

  // A request only interrupts if it beats every level already in service.
  assign reqValid = (req != 8'd0) && ((isr_q == 8'd0) || (topReq < topIsr));

  // Clears are applied before sets so that a level being acknowledged in the
  // same cycle as an EOI for that level stays in service.
  always_comb begin
    isrSet = 8'd0;
    isrClr = 8'd0;
    if (state_q == IDLE && fall && reqValid) isrSet[topReq] = 1'b1;
    if (eoi) begin
      if (eoi_specific)         isrClr[eoi_level] = 1'b1;
      else if (isr_q != 8'd0)   isrClr[topIsr]    = 1'b1;
    end
    if (state_q == ACK2 && rise && aeoi && !spur_q) isrClr[lvl_q] = 1'b1;
    isr_d = (isr_q & ~isrClr) | isrSet;
  end

  // Handshake FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      inta_prev_q <= 1'b1;
      int_q       <= 1'b0;
      chosen_q    <= 8'd0;
      isr_q       <= 8'd0;
      data_out_q  <= 8'd0;
      data_oe_q   <= 1'b0;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
    end else begin
      inta_prev_q <= INTA_N;
      isr_q       <= isr_d;
      chosen_q    <= 8'd0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= ACK1;
            int_q   <= 1'b0;
            if (reqValid) begin
              lvl_q    <= topReq;
              spur_q   <= 1'b0;
              chosen_q <= 8'd1 << topReq;
            end else begin
              // Spurious acknowledge: vector reports level 7, nothing serviced.
              lvl_q  <= 3'd7;
              spur_q <= 1'b1;
            end
          end else begin
            int_q <= reqValid;
          end
        end
        ACK1: begin
          int_q <= 1'b0;
          if (rise) state_q <= WAIT2;
        end
        WAIT2: begin
          int_q <= 1'b0;
          if (fall) begin
            state_q    <= ACK2;
            data_out_q <= {vec_base, lvl_q};
            data_oe_q  <= 1'b1;
          end
        end
        ACK2: begin
          int_q <= 1'b0;
          if (rise) begin
            state_q   <= IDLE;
            data_oe_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign INT      = int_q;
  assign chosen   = chosen_q;
  assign ISR      = isr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_ack_controller
//
// Drives the acknowledge controller through the directed scenarios (single
// request, nesting, EOI, AEOI with masking, spurious acknowledge, reset in
// the middle of a handshake) and then a long randomized run. A behavioural
// model tracks the handshake as a count of INTA edges and predicts every
// output after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_interrupt_ack_controller;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IRR;
  logic [7:0] IMR;
  logic       INTA_N;
  logic [4:0] vec_base;
  logic       aeoi;
  logic       eoi;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       INT;
  logic [7:0] chosen;
  logic [7:0] ISR;
  logic [7:0] data_out;
  logic       data_oe;

  interrupt_ack_controller #(.VEC_W(5)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .IRR          (IRR),
    .IMR          (IMR),
    .INTA_N       (INTA_N),
    .vec_base     (vec_base),
    .aeoi         (aeoi),
    .eoi          (eoi),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .INT          (INT),
    .chosen       (chosen),
    .ISR          (ISR),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  always #5 CLK = ~CLK;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: mPhase counts INTA edges seen within the current handshake.
  int         mPhase;
  int         mLvl;
  bit         mIntaPrev;
  bit         mSpur;
  bit         mInt;
  bit         mOe;
  logic [7:0] mChosen;
  logic [7:0] mIsr;
  logic [7:0] mData;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mPhase    = 0;
    mLvl      = 0;
    mIntaPrev = 1'b1;
    mSpur     = 1'b0;
    mInt      = 1'b0;
    mOe       = 1'b0;
    mChosen   = 8'd0;
    mIsr      = 8'd0;
    mData     = 8'd0;
  endtask

  // Applies the controller's rules to the inputs present at a rising edge.
  task automatic modelEdge();
    int         hiReq = 8;
    int         hiIsr = 8;
    logic [7:0] reqBits;
    logic [7:0] nIsr;
    bit         valid;
    bit         fallSeen;
    bit         riseSeen;
    reqBits = IRR & ~IMR;
    for (int i = 0; i < 8; i++) begin
      if (reqBits[i] && hiReq == 8) hiReq = i;
      if (mIsr[i] && hiIsr == 8)    hiIsr = i;
    end
    valid    = (hiReq < hiIsr);
    fallSeen = mIntaPrev && !INTA_N;
    riseSeen = !mIntaPrev && INTA_N;
    nIsr     = mIsr;
    if (eoi) begin
      if (eoi_specific)  nIsr[eoi_level] = 1'b0;
      else if (hiIsr < 8) nIsr[hiIsr]    = 1'b0;
    end
    mChosen = 8'd0;
    case (mPhase)
      0: begin
        if (fallSeen) begin
          mPhase = 1;
          mInt   = 1'b0;
          if (valid) begin
            mLvl        = hiReq;
            mSpur       = 1'b0;
            mChosen     = 8'(1 << hiReq);
            nIsr[hiReq] = 1'b1;
          end else begin
            mLvl  = 7;
            mSpur = 1'b1;
          end
        end else begin
          mInt = valid;
        end
      end
      1: if (riseSeen) mPhase = 2;
      2: if (fallSeen) begin
        mPhase = 3;
        mData  = 8'(vec_base * 8 + mLvl);
        mOe    = 1'b1;
      end
      default: if (riseSeen) begin
        mPhase = 0;
        mOe    = 1'b0;
        if (aeoi && !mSpur) nIsr[mLvl] = 1'b0;
      end
    endcase
    mIsr      = nIsr;
    mIntaPrev = INTA_N;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".INT"},      INT,      mInt);
    checkOutput({tag, ".chosen"},   chosen,   mChosen);
    checkOutput({tag, ".ISR"},      ISR,      mIsr);
    checkOutput({tag, ".data_out"}, data_out, mData);
    checkOutput({tag, ".data_oe"},  data_oe,  mOe);
  endtask

  task automatic stepCycle(input string tag);
    @(posedge CLK);
    if (RST_N) modelEdge();
    #1;
    compareAll(tag);
  endtask

  task automatic applyStimulus(input logic [7:0] irr, input logic [7:0] imr,
                               input logic inta);
    IRR    = irr;
    IMR    = imr;
    INTA_N = inta;
  endtask

  task automatic sendEoi(input logic specific, input logic [2:0] lvl);
    eoi          = 1'b1;
    eoi_specific = specific;
    eoi_level    = lvl;
    stepCycle("eoi");
    eoi          = 1'b0;
  endtask

  task automatic handshake(input string tag);
    INTA_N = 1'b0; stepCycle(tag);
    INTA_N = 1'b1; stepCycle(tag);
    INTA_N = 1'b0; stepCycle(tag);
    INTA_N = 1'b1; stepCycle(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic midCycleReset(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".INT"},      INT,      8'd0);
    checkOutput({tag, ".chosen"},   chosen,   8'd0);
    checkOutput({tag, ".ISR"},      ISR,      8'd0);
    checkOutput({tag, ".data_out"}, data_out, 8'd0);
    checkOutput({tag, ".data_oe"},  data_oe,  8'd0);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N        = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b1);
    vec_base     = 5'h10;
    aeoi         = 1'b0;
    eoi          = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
    modelReset();
    #1;
    compareAll("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Single request on IR3.
    IRR = 8'h08;
    stepCycle("single");
    checkOutput("single.int_latency", INT, 8'd1);
    INTA_N = 1'b0; stepCycle("single");
    checkOutput("single.chosen", chosen, 8'h08);
    checkOutput("single.isr", ISR, 8'h08);
    checkOutput("single.int_low", INT, 8'd0);
    INTA_N = 1'b1; stepCycle("single");
    checkOutput("single.chosen_once", chosen, 8'h00);
    INTA_N = 1'b0; stepCycle("single");
    checkOutput("single.vector", data_out, 8'h83);
    checkOutput("single.oe", data_oe, 8'd1);
    INTA_N = 1'b1; stepCycle("single");
    checkOutput("single.oe_off", data_oe, 8'd0);
    checkOutput("single.vector_hold", data_out, 8'h83);
    IRR = 8'h00;
    sendEoi(1'b1, 3'd3);
    checkOutput("single.eoi", ISR, 8'h00);

    // Priority and nesting.
    IRR = 8'h24;
    stepCycle("nest");
    handshake("nest");
    checkOutput("nest.isr_lvl2", ISR, 8'h04);
    IRR = 8'h20;
    stepCycle("nest");
    checkOutput("nest.ir5_blocked", INT, 8'd0);
    IRR = 8'h21;
    stepCycle("nest");
    checkOutput("nest.ir0_preempts", INT, 8'd1);
    handshake("nest");
    checkOutput("nest.isr_nested", ISR, 8'h05);
    checkOutput("nest.vector0", data_out, 8'h80);

    // EOI retirement, IR5 still pending.
    IRR = 8'h20;
    sendEoi(1'b0, 3'd0);
    checkOutput("eoi.nonspecific", ISR, 8'h04);
    sendEoi(1'b1, 3'd2);
    checkOutput("eoi.specific", ISR, 8'h00);
    stepCycle("eoi");
    checkOutput("eoi.int_again", INT, 8'd1);
    handshake("eoi");
    IRR = 8'h00;
    sendEoi(1'b0, 3'd0);

    // AEOI with IR0 masked.
    aeoi = 1'b1;
    applyStimulus(8'h81, 8'h01, 1'b1);
    stepCycle("aeoi");
    handshake("aeoi");
    checkOutput("aeoi.vector7", data_out, 8'h87);
    checkOutput("aeoi.isr_cleared", ISR, 8'h00);
    aeoi = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b1);

    // Spurious acknowledge: request withdrawn before the first fall.
    vec_base = 5'h1A;
    IRR = 8'h02;
    stepCycle("spur");
    applyStimulus(8'h00, 8'h00, 1'b0);
    stepCycle("spur");
    checkOutput("spur.chosen", chosen, 8'h00);
    checkOutput("spur.isr", ISR, 8'h00);
    INTA_N = 1'b1; stepCycle("spur");
    INTA_N = 1'b0; stepCycle("spur");
    checkOutput("spur.vector", data_out, 8'hD7);
    INTA_N = 1'b1; stepCycle("spur");

    // Reset while waiting for the second pulse, then a fresh acknowledge.
    IRR = 8'h04;
    stepCycle("rstw2");
    INTA_N = 1'b0; stepCycle("rstw2");
    INTA_N = 1'b1; stepCycle("rstw2");
    midCycleReset("rstw2");
    INTA_N = 1'b0; stepCycle("rstw2");
    checkOutput("rstw2.idle_ack", chosen, 8'h04);
    checkOutput("rstw2.no_oe", data_oe, 8'd0);
    INTA_N = 1'b1; stepCycle("rstw2");
    INTA_N = 1'b0; stepCycle("rstw2");
    INTA_N = 1'b1; stepCycle("rstw2");

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0)  IRR = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) IMR = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 2) == 0)  INTA_N = ~INTA_N;
      if ($urandom_range(0, 19) == 0) aeoi = ~aeoi;
      if ($urandom_range(0, 19) == 0) vec_base = 5'($urandom);
      eoi          = ($urandom_range(0, 5) == 0);
      eoi_specific = 1'($urandom);
      eoi_level    = 3'($urandom);
      if ($urandom_range(0, 199) == 0) midCycleReset("rand.rst");
      stepCycle("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
